// File: rtl/text_rom_pkg.sv
// Shared types and default constants for the text ROM streamer.
// Build option: TEXT_ROM_TERMINATOR_EN (consumed by text_rom_streamer).
package text_rom_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SEND  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [7:0] DEFAULT_FILL = 8'h20;  // ASCII space
  localparam logic [7:0] DEFAULT_TERM = 8'h00;

endpackage

// File: rtl/text_rom_streamer_if.sv
// Request/character-stream bundle between a client (master) and the streamer (slave).
interface text_rom_streamer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
);
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W:0]   length;
  logic              abort;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;

  modport master (
    output start, start_addr, length, abort, out_ready,
    input  out_data, out_valid, busy, done
  );

  modport slave (
    input  start, start_addr, length, abort, out_ready,
    output out_data, out_valid, busy, done
  );
endinterface

// File: rtl/text_rom_streamer_rom.sv
// Constant character table with a registered read port (one cycle of latency).
// Unprogrammed addresses return FILL.
module text_rom
  import text_rom_pkg::*;
#(
  parameter int                DATA_W = 8,
  parameter int                ADDR_W = 6,
  parameter logic [DATA_W-1:0] FILL   = DATA_W'(DEFAULT_FILL)
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [DATA_W-1:0] data_o
);

  logic [DATA_W-1:0] rom_val;

  // NOTE: every path through always_comb assigns rom_val (default first), so no latch is inferred.
  always_comb begin
    rom_val = FILL;
    case (int'(addr_i))
      // "HELLO, WORLD!"
      0:  rom_val = DATA_W'(8'h48);
      1:  rom_val = DATA_W'(8'h45);
      2:  rom_val = DATA_W'(8'h4C);
      3:  rom_val = DATA_W'(8'h4C);
      4:  rom_val = DATA_W'(8'h4F);
      5:  rom_val = DATA_W'(8'h2C);
      6:  rom_val = DATA_W'(8'h20);
      7:  rom_val = DATA_W'(8'h57);
      8:  rom_val = DATA_W'(8'h4F);
      9:  rom_val = DATA_W'(8'h52);
      10: rom_val = DATA_W'(8'h4C);
      11: rom_val = DATA_W'(8'h44);
      12: rom_val = DATA_W'(8'h21);
      // "AB", terminator, "CDEFGHIJ"
      16: rom_val = DATA_W'(8'h41);
      17: rom_val = DATA_W'(8'h42);
      18: rom_val = DATA_W'(8'h00);
      19: rom_val = DATA_W'(8'h43);
      20: rom_val = DATA_W'(8'h44);
      21: rom_val = DATA_W'(8'h45);
      22: rom_val = DATA_W'(8'h46);
      23: rom_val = DATA_W'(8'h47);
      24: rom_val = DATA_W'(8'h48);
      25: rom_val = DATA_W'(8'h49);
      26: rom_val = DATA_W'(8'h4A);
      // "xyz#" at the top of the address space
      60: rom_val = DATA_W'(8'h78);
      61: rom_val = DATA_W'(8'h79);
      62: rom_val = DATA_W'(8'h7A);
      63: rom_val = DATA_W'(8'h23);
      default: rom_val = FILL;
    endcase
  end

  // NOTE: the read register carries no reset; its content is meaningless until an address is presented.
  always_ff @(posedge clk) begin
    data_o <= rom_val;
  end

endmodule

// File: rtl/text_rom_streamer.sv
// Streams a run of characters from text_rom over a valid/ready handshake.
// Build option: TEXT_ROM_TERMINATOR_EN stops a string early at the TERM character.
module text_rom_streamer
  import text_rom_pkg::*;
#(
  parameter int                DATA_W = 8,
  parameter int                ADDR_W = 6,
  parameter logic [DATA_W-1:0] FILL   = DATA_W'(DEFAULT_FILL),
  parameter logic [DATA_W-1:0] TERM   = DATA_W'(DEFAULT_TERM)
) (
  input  logic               clk,
  input  logic               rst,
  text_rom_streamer_if.slave bus
);

`ifdef TEXT_ROM_TERMINATOR_EN
  localparam bit TERM_EN = 1'b1;
`else
  localparam bit TERM_EN = 1'b0;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] rom_data;
  logic              term_hit;

  // The ROM is addressed with the next-state address so the word for addr_q is ready during FETCH.
  text_rom #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .FILL   (FILL)
  ) u_rom (
    .clk    (clk),
    .addr_i (addr_d),
    .data_o (rom_data)
  );

  assign term_hit = TERM_EN && (rom_data == TERM);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          addr_d  = bus.start_addr;
          cnt_d   = bus.length;
          state_d = (bus.length == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        data_d  = rom_data;
        state_d = term_hit ? S_DONE : S_SEND;
      end
      S_SEND: begin
        if (bus.out_ready) begin
          if (cnt_q > (ADDR_W+1)'(1)) begin
            addr_d  = addr_q + 1'b1;  // wraps modulo DEPTH
            cnt_d   = cnt_q - 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort wins over any handshake taking place in the same cycle.
    if (bus.abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  assign bus.out_valid = (state_q == S_SEND) && !bus.abort;
  assign bus.out_data  = data_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);

endmodule

// File: tb/tb_text_rom_streamer.sv
// Randomised scoreboard bench for text_rom_streamer against a table-and-queue reference model.
module tb_text_rom_streamer;
  import text_rom_pkg::*;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 2**ADDR_W;
  localparam int BUDGET = 3000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  text_rom_streamer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  text_rom_streamer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] rom_model [DEPTH];
  logic [7:0] exp_q [$];
  bit         expect_done = 1'b0;
  bit         done_seen   = 1'b0;
  int         done_cyc    = 0;
  int         last_hs_cyc = 0;
  int         hs_cnt      = 0;

  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  logic [7:0] prev_data  = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void init_model();
    string      s1;
    logic [7:0] s2 [11];
    string      s3;
    for (int a = 0; a < DEPTH; a++) rom_model[a] = 8'h20;
    s1 = "HELLO, WORLD!";
    for (int i = 0; i < s1.len(); i++) rom_model[i] = s1[i];
    s2 = '{8'h41, 8'h42, 8'h00, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h49, 8'h4A};
    for (int i = 0; i < 11; i++) rom_model[16+i] = s2[i];
    s3 = "xyz#";
    for (int i = 0; i < 4; i++) rom_model[60+i] = s3[i];
  endfunction

  // Expected characters: walk len addresses modulo DEPTH, optionally stopping at the terminator.
  function automatic void push_expected(input int addr, input int len);
    logic [7:0] c;
    for (int i = 0; i < len; i++) begin
      c = rom_model[(addr + i) % DEPTH];
`ifdef TEXT_ROM_TERMINATOR_EN
      if (c == DEFAULT_TERM) break;
`endif
      exp_q.push_back(c);
    end
  endfunction

  // Monitor: pops the scoreboard on every handshake and polices stalls and done pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid && bus.out_ready) begin
        check("char_expected", 64'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("char_value", bus.out_data, exp_q.pop_front());
        hs_cnt++;
        last_hs_cyc = cyc;
      end
      if (prev_valid && !prev_ready && !bus.abort) begin
        check("stall_valid_held", bus.out_valid, 1);
        check("stall_data_held", bus.out_data, prev_data);
      end
      if (bus.done) begin
        check("done_expected", expect_done, 1);
        expect_done = 1'b0;
        done_seen   = 1'b1;
        done_cyc    = cyc;
      end
    end
    prev_valid = bus.out_valid && !rst;
    prev_ready = bus.out_ready;
    prev_data  = bus.out_data;
  end

  // Issues one string; random start/addr/length are driven while busy and must be ignored.
  task automatic run_string(input int addr, input int len, input int ready_pct,
                            input int hold, input int abort_at, input bit post_rst);
    int k;
    int first_valid;
    int start_cyc;
    int n_exp;
    k = 0;
    first_valid = -1;
    push_expected(addr, len);
    n_exp = exp_q.size();
    hs_cnt = 0;
    done_seen = 1'b0;
    last_hs_cyc = 0;
    done_cyc = 0;
    @(posedge clk); #1;
    if (post_rst) rst = 1'b0;
    bus.start      = 1'b1;
    bus.start_addr = ADDR_W'(addr);
    bus.length     = (ADDR_W+1)'(len);
    bus.out_ready  = 1'b0;
    bus.abort      = 1'b0;
    expect_done    = (abort_at < 0);
    start_cyc      = cyc;
    @(negedge clk); #1;
    if (post_rst) begin
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_out_data", bus.out_data, 0);
    end
    forever begin
      @(posedge clk); #1;
      k++;
      bus.start      = 1'($urandom_range(1));
      bus.start_addr = ADDR_W'($urandom);
      bus.length     = (ADDR_W+1)'($urandom_range(DEPTH));
      bus.out_ready  = (k > hold) && ($urandom_range(99) < ready_pct);
      bus.abort      = (k == abort_at);
      if (k == abort_at) bus.start = 1'b0;
      @(negedge clk); #1;
      if (bus.out_valid && first_valid < 0) first_valid = k;
      if (k == abort_at || done_seen || k > BUDGET) break;
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.out_ready = 1'b0;
    if (abort_at >= 0 && k == abort_at) begin
      @(negedge clk); #1;
      check("abort_busy_cleared", bus.busy, 0);
      check("abort_valid_cleared", bus.out_valid, 0);
      check("abort_handshakes", hs_cnt, (abort_at - 1) / 2);
      exp_q.delete();
      repeat (3) @(negedge clk);
    end else begin
      check("string_finished", done_seen, 1);
      check("chars_left", exp_q.size(), 0);
      exp_q.delete();
      if (n_exp > 0) begin
        check("first_valid_latency", first_valid, 2);
        check("done_after_last_char", done_cyc - last_hs_cyc, (n_exp == len) ? 1 : 2);
        if (ready_pct == 100 && hold == 0 && n_exp == len)
          check("full_rate_done_cycle", done_cyc - start_cyc, 2 * len + 1);
      end else begin
        check("no_valid_empty_string", first_valid, -1);
        check("empty_done_within_2", 64'((done_cyc - start_cyc) inside {[1:2]}), 1);
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t, expected finish earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    init_model();
    bus.start      = 1'b0;
    bus.start_addr = '0;
    bus.length     = '0;
    bus.abort      = 1'b0;
    bus.out_ready  = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_out_data", bus.out_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_string(0, 9, 100, 0, -1, 1'b0);   // basic string, full rate
    run_string(62, 4, 100, 0, -1, 1'b0);  // address wrap 62,63,0,1
    run_string(0, 9, 100, 6, -1, 1'b0);   // five stalled SEND cycles
    run_string(5, 0, 100, 0, -1, 1'b0);   // empty string
    run_string(16, 10, 100, 0, -1, 1'b0); // terminator at third character
    run_string(0, 9, 100, 0, 5, 1'b0);    // abort in FETCH
    run_string(60, 8, 100, 0, 4, 1'b0);   // abort in SEND with out_ready high

    // Reset mid-string, then start on the first cycle after reset releases.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.start_addr = '0; bus.length = 7'd9; bus.out_ready = 1'b0;
    expect_done = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk); #1;
    exp_q.delete();
    run_string(20, 5, 100, 0, -1, 1'b1);

    for (int n = 0; n < 14; n++) begin
      int a, l, r;
      a = int'($urandom_range(DEPTH - 1));
      l = (n % 5 == 0) ? int'($urandom_range(3)) : int'($urandom_range(DEPTH));
      case (n % 3)
        0:       r = 100;
        1:       r = 70;
        default: r = 40;
      endcase
      run_string(a, l, r, 0, -1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
